// File: rtl/spi_pkg.sv
// Shared definitions for the clk-domain SPI slave: FSM encoding, pin bit
// positions inside the synchroniser bundle and the bit-counter width helper.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  localparam int PIN_SS   = 0;
  localparam int PIN_SCLK = 1;
  localparam int PIN_MOSI = 2;

  // Level the pins are assumed to sit at while the bus is idle: ss high, sclk low, mosi low.
  localparam logic [2:0] PIN_IDLE = 3'b001;

  function automatic int spi_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchroniser for asynchronous pins plus one delay flop per bit,
// giving synced levels and single-cycle rise/fall strobes in the clk domain.
module spi_in_sync #(
  parameter int               WIDTH       = 3,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]                  dly_q, dly_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    dly_d = stage_q[SYNC_STAGES-1];
  end

  // Reset loads the idle pattern so releasing reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= {SYNC_STAGES{IDLE_VAL}};
      dly_q   <= IDLE_VAL;
    end else begin
      stage_q <= stage_d;
      dly_q   <= dly_d;
    end
  end

  assign level = stage_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave fully retimed into clk: pins are oversampled, SCLK edges become
// strobes, and whole words are exchanged through a tx holding register and an rx strobe.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              rx_negedge,
  input  logic              tx_negedge,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int               CNT_W     = spi_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_W);

  logic [2:0] pin_lvl, pin_rise, pin_fall;
  logic       ss_lvl, ss_fall, mosi_lvl;
  logic       rx_edge, tx_edge;
  logic       unused_pins;

  spi_in_sync #(
    .WIDTH       (3),
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_VAL    (PIN_IDLE)
  ) u_in_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({mosi, sclk, ss}),
    .level (pin_lvl),
    .rise  (pin_rise),
    .fall  (pin_fall)
  );

  assign ss_lvl   = pin_lvl[PIN_SS];
  assign ss_fall  = pin_fall[PIN_SS];
  assign mosi_lvl = pin_lvl[PIN_MOSI];
  assign rx_edge  = rx_negedge ? pin_fall[PIN_SCLK] : pin_rise[PIN_SCLK];
  assign tx_edge  = tx_negedge ? pin_fall[PIN_SCLK] : pin_rise[PIN_SCLK];

  assign unused_pins = &{1'b0, pin_lvl[PIN_SCLK], pin_rise[PIN_SS],
                         pin_rise[PIN_MOSI], pin_fall[PIN_MOSI]};

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              load_tx;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    tx_sr_d       = tx_sr_q;
    rx_sr_d       = rx_sr_q;
    rx_cnt_d      = rx_cnt_q;
    tx_cnt_d      = tx_cnt_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    load_tx       = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d  = ST_ACTIVE;
          load_tx  = 1'b1;
          rx_sr_d  = '0;
          rx_cnt_d = '0;
          tx_cnt_d = '0;
        end
      end

      ST_ACTIVE: begin
        if (ss_lvl) begin
          // Master gave up mid-word: drop partial rx and unsent tx, keep the holding reg.
          state_d  = ST_IDLE;
          tx_sr_d  = '0;
          rx_sr_d  = '0;
          rx_cnt_d = '0;
          tx_cnt_d = '0;
        end else if (rx_cnt_q == WORD_BITS) begin
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          rx_cnt_d   = '0;
          tx_cnt_d   = '0;
          load_tx    = 1'b1;
        end else begin
          if (rx_edge) begin
            if (LSB_FIRST != 0) begin
              rx_sr_d = {mosi_lvl, rx_sr_q[DATA_W-1:1]};
            end else begin
              rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi_lvl};
            end
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
          // The tx side only advances once rx has consumed the bit on the line;
          // this keeps the first launch edge and the post-word edge from shifting.
          if (tx_edge && (rx_cnt_q > tx_cnt_q)) begin
            if (LSB_FIRST != 0) begin
              tx_sr_d = {1'b0, tx_sr_q[DATA_W-1:1]};
            end else begin
              tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
            end
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (load_tx) begin
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d       = '0;
        tx_underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      tx_sr_q       <= '0;
      rx_sr_q       <= '0;
      rx_cnt_q      <= '0;
      tx_cnt_q      <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      tx_sr_q       <= tx_sr_d;
      rx_sr_q       <= rx_sr_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  always_comb begin
    miso = 1'b0;
    if (state_q == ST_ACTIVE) begin
      miso = (LSB_FIRST != 0) ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
    end
  end

  assign busy        = (state_q == ST_ACTIVE);
  assign miso_oe     = busy;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: an 8-bit MSB-first slave (a) and a
// 16-bit LSB-first slave (b) share sclk/mosi, each with its own ss.
module tb_spi_slave_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss_a, ss_b, sclk, mosi;
  logic        rx_negedge, tx_negedge;
  logic        miso_a, miso_oe_a, tx_ready_a, rx_valid_a, tx_underrun_a, busy_a;
  logic        miso_b, miso_oe_b, tx_ready_b, rx_valid_b, tx_underrun_b, busy_b;
  logic [7:0]  tx_data_a, rx_data_a;
  logic [15:0] tx_data_b, rx_data_b;
  logic        tx_valid_a, tx_valid_b;

  int checks = 0;
  int errors = 0;
  int rxv_a = 0, rxv_b = 0, urun_a = 0, urun_b = 0;
  logic [15:0] rxlog_b [4];
  int rxv_base, urun_base;
  logic [15:0] cap;

  always #5 clk = ~clk;

  spi_slave_sync #(.DATA_W(8), .LSB_FIRST(0), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ss(ss_a), .sclk(sclk), .mosi(mosi),
    .miso(miso_a), .miso_oe(miso_oe_a), .rx_negedge(rx_negedge), .tx_negedge(tx_negedge),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .tx_underrun(tx_underrun_a), .busy(busy_a)
  );

  spi_slave_sync #(.DATA_W(16), .LSB_FIRST(1), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ss(ss_b), .sclk(sclk), .mosi(mosi),
    .miso(miso_b), .miso_oe(miso_oe_b), .rx_negedge(rx_negedge), .tx_negedge(tx_negedge),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .tx_underrun(tx_underrun_b), .busy(busy_b)
  );

  // Strobe monitor, sampled on the falling clk edge away from the active edge.
  always @(negedge clk) begin
    if (rx_valid_a === 1'b1) rxv_a++;
    if (tx_underrun_a === 1'b1) urun_a++;
    if (tx_underrun_b === 1'b1) urun_b++;
    if (rx_valid_b === 1'b1) begin
      if (rxv_b < 4) rxlog_b[rxv_b] = rx_data_b;
      rxv_b++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int sel, input logic [15:0] data);
    int guard = 0;
    while (((sel != 0) ? tx_ready_b : tx_ready_a) !== 1'b1 && guard < 200) begin
      tick(1);
      guard++;
    end
    check_output("load_ready", 32'((sel != 0) ? tx_ready_b : tx_ready_a), 32'd1);
    if (sel != 0) begin
      tx_data_b  = data;
      tx_valid_b = 1'b1;
    end else begin
      tx_data_a  = data[7:0];
      tx_valid_a = 1'b1;
    end
    tick(1);
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
  endtask

  // Master model: mosi changes after each falling edge, miso sampled just before rising.
  task automatic apply_stimulus(input int sel, input int nbits, input bit lsb,
                                input logic [15:0] mo, input int half,
                                output logic [15:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx  = lsb ? i : nbits - 1 - i;
      mosi = mo[idx];
      tick(half);
      mi[idx] = (sel != 0) ? miso_b : miso_a;
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; ss_a = 1'b1; ss_b = 1'b1; sclk = 1'b0; mosi = 1'b0;
    rx_negedge = 1'b0; tx_negedge = 1'b1;
    tx_data_a = '0; tx_data_b = '0; tx_valid_a = 1'b0; tx_valid_b = 1'b0;

    // 1: reset values
    tick(3);
    check_output("rst_miso", 32'(miso_a), 32'd0);
    check_output("rst_miso_oe", 32'(miso_oe_a), 32'd0);
    check_output("rst_tx_ready", 32'(tx_ready_a), 32'd1);
    check_output("rst_rx_valid", 32'(rx_valid_a), 32'd0);
    check_output("rst_busy", 32'(busy_a), 32'd0);
    check_output("rst_rx_data", 32'(rx_data_a), 32'd0);
    check_output("rst_underrun", 32'(tx_underrun_a), 32'd0);
    check_output("rst_tx_ready_b", 32'(tx_ready_b), 32'd1);
    rst_n = 1'b1;
    tick(2);

    // 2: mode 0, tx 0xA5, master sends 0x3C
    $display("[TB] step 2: mode 0 single word");
    load_word(0, 16'h00A5);
    check_output("c2_tx_ready_low", 32'(tx_ready_a), 32'd0);
    rxv_base = rxv_a; urun_base = urun_a;
    ss_a = 1'b0;
    tick(4);
    check_output("c2_busy", 32'(busy_a), 32'd1);
    check_output("c2_miso_oe", 32'(miso_oe_a), 32'd1);
    check_output("c2_tx_ready_back", 32'(tx_ready_a), 32'd1);
    check_output("c2_no_underrun", 32'(urun_a - urun_base), 32'd0);
    apply_stimulus(0, 8, 1'b0, 16'h003C, 8, cap);
    tick(4);
    check_output("c2_master_rx", 32'(cap), 32'h00A5);
    check_output("c2_rx_data", 32'(rx_data_a), 32'h3C);
    check_output("c2_rx_valid_cnt", 32'(rxv_a - rxv_base), 32'd1);
    ss_a = 1'b1;
    tick(6);
    check_output("c2_busy_end", 32'(busy_a), 32'd0);

    // 3: LSB first, 16 bit, back-to-back words
    $display("[TB] step 3: 16-bit LSB-first back-to-back");
    load_word(1, 16'h8001);
    rxv_base = rxv_b; urun_base = urun_b;
    ss_b = 1'b0;
    tick(4);
    load_word(1, 16'h55AA);
    apply_stimulus(1, 16, 1'b1, 16'h1234, 8, cap);
    check_output("c3_master_rx0", 32'(cap), 32'h8001);
    load_word(1, 16'h0000);
    apply_stimulus(1, 16, 1'b1, 16'hBEEF, 8, cap);
    tick(4);
    check_output("c3_master_rx1", 32'(cap), 32'h55AA);
    check_output("c3_rx_valid_cnt", 32'(rxv_b - rxv_base), 32'd2);
    check_output("c3_rx_word0", 32'(rxlog_b[rxv_base]), 32'h1234);
    check_output("c3_rx_word1", 32'(rxlog_b[rxv_base + 1]), 32'hBEEF);
    ss_b = 1'b1;
    tick(6);
    check_output("c3_no_underrun", 32'(urun_b - urun_base), 32'd0);

    // 4: empty holding register at ss fall
    $display("[TB] step 4: underrun");
    rxv_base = rxv_a; urun_base = urun_a;
    ss_a = 1'b0;
    tick(4);
    check_output("c4_underrun_pulse", 32'(urun_a - urun_base), 32'd1);
    check_output("c4_underrun_width", 32'(tx_underrun_a), 32'd0);
    apply_stimulus(0, 8, 1'b0, 16'h0096, 8, cap);
    tick(4);
    check_output("c4_master_rx", 32'(cap), 32'h0000);
    check_output("c4_rx_data", 32'(rx_data_a), 32'h96);
    check_output("c4_rx_valid_cnt", 32'(rxv_a - rxv_base), 32'd1);
    ss_a = 1'b1;
    tick(6);

    // 5: abort after 5 bits, then a clean word
    $display("[TB] step 5: abort");
    load_word(0, 16'h0011);
    rxv_base = rxv_a;
    ss_a = 1'b0;
    tick(4);
    load_word(0, 16'h0022);
    apply_stimulus(0, 5, 1'b0, 16'h001B, 8, cap);
    ss_a = 1'b1;
    tick(6);
    check_output("c5_no_rx_valid", 32'(rxv_a - rxv_base), 32'd0);
    check_output("c5_rx_data_kept", 32'(rx_data_a), 32'h96);
    check_output("c5_busy", 32'(busy_a), 32'd0);
    check_output("c5_miso_oe", 32'(miso_oe_a), 32'd0);
    check_output("c5_hold_kept", 32'(tx_ready_a), 32'd0);
    ss_a = 1'b0;
    tick(4);
    apply_stimulus(0, 8, 1'b0, 16'h005A, 8, cap);
    tick(4);
    check_output("c5_master_rx", 32'(cap), 32'h0022);
    check_output("c5_rx_data", 32'(rx_data_a), 32'h5A);
    check_output("c5_rx_valid_cnt", 32'(rxv_a - rxv_base), 32'd1);
    ss_a = 1'b1;
    tick(6);

    // 6: both edges rising, SCLK = clk/4, then reset mid-word
    $display("[TB] step 6: same-edge mode at clk/4");
    rx_negedge = 1'b0; tx_negedge = 1'b0;
    tick(2);
    load_word(0, 16'h00C3);
    rxv_base = rxv_a;
    ss_a = 1'b0;
    tick(4);
    apply_stimulus(0, 8, 1'b0, 16'h00E7, 2, cap);
    tick(6);
    check_output("c6_rx_data", 32'(rx_data_a), 32'hE7);
    check_output("c6_rx_valid_cnt", 32'(rxv_a - rxv_base), 32'd1);
    ss_a = 1'b1;
    tick(6);

    load_word(0, 16'h0077);
    rxv_base = rxv_a; urun_base = urun_a;
    ss_a = 1'b0;
    tick(4);
    apply_stimulus(0, 3, 1'b0, 16'h0005, 2, cap);
    rst_n = 1'b0;
    tick(1);
    check_output("c6_rst_busy", 32'(busy_a), 32'd0);
    check_output("c6_rst_miso_oe", 32'(miso_oe_a), 32'd0);
    check_output("c6_rst_miso", 32'(miso_a), 32'd0);
    check_output("c6_rst_tx_ready", 32'(tx_ready_a), 32'd1);
    check_output("c6_rst_rx_valid", 32'(rx_valid_a), 32'd0);
    check_output("c6_rst_rx_data", 32'(rx_data_a), 32'd0);
    check_output("c6_rst_underrun", 32'(tx_underrun_a), 32'd0);
    ss_a = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check_output("c6_no_strobes", 32'((rxv_a - rxv_base) + (urun_a - urun_base)), 32'd0);
    check_output("c6_idle_after", 32'(busy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
